matmul_operand_feeder: RTL and testbench
========================================

// Module: matmul_operand_feeder
// PURPOSE
//  Upstream stage of the systolic matmul array. Reads one A-column/B-row slice per k-step from operand SRAM.
//  Skews each lane diagonally (lane i delayed i cycles), then drives the west (a) and north (b) edges of the PE grid.
//  Owns the PE 'start' enable: holds it high through feed, flush and result hold; drops it to clear the accumulators.
// PARAMETERS
//  N           4    array dimension (lanes per edge), >=2
//  DATA_WIDTH  16   operand element width
//  ADDR_W      8    operand SRAM address width
//  K_W         8    width of k_len (max K = 2**K_W-1)
// PORTS
//  clk         in   1              clock
//  reset       in   1              asynchronous, active-low
//  go          in   1              launch request, sampled in IDLE only
//  k_len       in   K_W            number of k-steps; sampled with go
//  busy        out  1              high in FEED/FLUSH/DONE
//  done        out  1              high in DONE until done_ack
//  done_ack    in   1              result readout finished; releases PEs
//  rd_en       out  1              SRAM read strobe
//  rd_addr     out  ADDR_W         SRAM address = k (0..K-1)
//  rd_a_data   in   N*DATA_WIDTH   A column k, lane i at [i*DW +: DW]; valid 1 cycle after rd_en
//  rd_b_data   in   N*DATA_WIDTH   B row k, same packing/latency
//  a_edge      out  N*DATA_WIDTH   skewed A to PE row i west input
//  b_edge      out  N*DATA_WIDTH   skewed B to PE column j north input
//  pe_start    out  1              start to every PE
// BEHAVIOUR
//  Reset: state IDLE; busy, done, rd_en, pe_start = 0; rd_addr = 0; a_edge, b_edge and all skew regs = 0.
//  Reset mid-operation aborts immediately to the same values; no SRAM read is issued after reset asserts.
//  FSM IDLE -> FEED -> FLUSH -> DONE -> IDLE.
//   IDLE: go=1 & k_len!=0 -> FEED, k cleared to 0. go=1 & k_len==0 -> DONE directly (no reads, edges stay 0).
//         go while not IDLE is ignored.
//   FEED: rd_en=1, rd_addr=k, k++ each cycle; after the k=K-1 read -> FLUSH. Exactly K reads, back-to-back.
//   FLUSH: rd_en=0; counts FLUSH_CYCLES = 1 + 3*(N-1) + 2
//          (read latency + max skew + max PE hops + mul/acc pipe); then -> DONE.
//   DONE: done=1, pe_start stays 1 (PE results held); done_ack=1 -> IDLE next cycle.
//         done_ack outside DONE is ignored.
//  pe_start = 1 in FEED, FLUSH and DONE; registered; rises the cycle FEED is entered.
//  Skew: returned slice captured 1 cycle after rd_en. Lane i of a_edge/b_edge presents element k
//        exactly i cycles after lane 0 presents it. Lane 0 edge = element k at cycle t0+k+1 (t0 = first FEED cycle).
//  Edge data are zero-filled whenever no valid read data enters a lane (FLUSH, DONE, IDLE).
//  Data passes bit-exact; no arithmetic and no sign extension (PEs handle sign extension).
//  Max k_len: K = 2**K_W-1 is legal; the k counter must not wrap before FEED exits.
// CONFIGURATION
//  FEEDER_CYCLE_CNT_EN defined: adds output cycle_cnt [31:0].
//   Cleared to 0 on accepted go; increments every FEED/FLUSH cycle; frozen in DONE/IDLE; saturates at 2**32-1; reset 0.
//  FEEDER_CYCLE_CNT_EN undefined: no port, no counter logic.
// STRUCTURE
//  Package matmul_pkg:
//   - feeder_state_t enum {IDLE, FEED, FLUSH, DONE}
//   - flush_cycles(N) function
//   - lane slice helper macros for DW packing
//  Sub-module skew_line #(DEPTH, DATA_WIDTH): DEPTH-stage shift register with async active-low clear.
//   Instantiated per lane for a and b with DEPTH=i; DEPTH=0 is a wire.
// TESTING
//  1 N=4, k_len=3, SRAM A[k][i]=16*k+i -> rd_addr 0,1,2 on consecutive cycles;
//    a_edge lane3 shows 0x03,0x13,0x23 three cycles after lane0 shows 0x00,0x10,0x20.
//  2 Full run, identity B, A=1..16 -> after done, PE results equal A; done_ack -> pe_start falls next cycle.
//  3 k_len=0 with go -> DONE next cycle, rd_en never asserted, edges stay 0.
//  4 Reset low mid-FEED at k=1 -> same cycle rd_en=0, pe_start=0, edges 0; go after release restarts at rd_addr 0.
//  5 go pulsed during FLUSH and done_ack pulsed during FEED -> both ignored; read count and FLUSH length unchanged.
//  6 FEEDER_CYCLE_CNT_EN, N=4, k_len=5 -> cycle_cnt = 5 + 12 = 17 in DONE; stays 17 until next go.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the systolic matmul operand feeder.
// Provides the feeder state enum, the flush-length function and lane slice macros.
`ifndef MATMUL_PKG_SV
`define MATMUL_PKG_SV

// Lane 'lane' of a vector packed as lanes of 'dw' bits, lane 0 in the LSBs
`define LANE_SLICE(vec, lane, dw) vec[(lane)*(dw) +: (dw)]

package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  // read latency + max skew + max PE hops + mul/acc pipe
  function automatic int unsigned flush_cycles(input int unsigned n);
    return 1 + 3 * (n - 1) + 2;
  endfunction

endpackage

`endif

// File: rtl/matmul_operand_feeder_if.sv
// Control, operand-SRAM read and PE-edge signals of the matmul operand feeder.
// master = feeder side, slave = sequencer/SRAM/array side.
interface matmul_operand_feeder_if #(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned K_W        = 8
);
  logic                    go;
  logic [K_W-1:0]          k_len;
  logic                    busy;
  logic                    done;
  logic                    done_ack;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [N*DATA_WIDTH-1:0] rd_a_data;
  logic [N*DATA_WIDTH-1:0] rd_b_data;
  logic [N*DATA_WIDTH-1:0] a_edge;
  logic [N*DATA_WIDTH-1:0] b_edge;
  logic                    pe_start;

  modport master (
    input  go, k_len, done_ack, rd_a_data, rd_b_data,
    output busy, done, rd_en, rd_addr, a_edge, b_edge, pe_start
  );

  modport slave (
    output go, k_len, done_ack, rd_a_data, rd_b_data,
    input  busy, done, rd_en, rd_addr, a_edge, b_edge, pe_start
  );
endinterface

// File: rtl/matmul_operand_feeder_skew_line.sv
// skew_line: DEPTH-stage shift register with async active-low clear.
// DEPTH=0 degenerates to a wire.
module skew_line #(
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_sr
      logic [DATA_WIDTH-1:0] sr [DEPTH];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < int'(DEPTH); s++) sr[s] <= '0;
        end else begin
          sr[0] <= d;
          for (int s = 1; s < int'(DEPTH); s++) sr[s] <= sr[s-1];
        end
      end

      assign q = sr[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/matmul_operand_feeder.sv
// Operand feeder for the systolic matmul array: reads K slices, skews lane i by i cycles.
// Optional FEEDER_CYCLE_CNT_EN adds a saturating FEED+FLUSH cycle counter output.
module matmul_operand_feeder
  import matmul_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned K_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
`ifdef FEEDER_CYCLE_CNT_EN
  output logic [31:0] cycle_cnt,
`endif
  matmul_operand_feeder_if.master bus
);
  localparam int unsigned FLUSH_N = flush_cycles(N);
  localparam int unsigned FL_W    = $clog2(FLUSH_N);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_N - 1);

  feeder_state_t   state_q, state_d;
  logic [K_W-1:0]  k_q, k_d, k_len_q, k_len_d;
  logic [FL_W-1:0] fl_q, fl_d;
  logic            busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, pe_q, pe_d;
  logic            rd_vld_q;
  logic            k_last_c, fl_last_c;

  assign k_last_c  = (k_q == K_W'(k_len_q - K_W'(1)));
  assign fl_last_c = (fl_q == FL_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.go) state_d = (bus.k_len == '0) ? DONE : FEED;
      FEED:    if (k_last_c) state_d = FLUSH;
      FLUSH:   if (fl_last_c) state_d = DONE;
      DONE:    if (bus.done_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and counter next values; outputs are registered from the next state
  always_comb begin
    k_d     = k_q;
    k_len_d = k_len_q;
    fl_d    = fl_q;
    case (state_q)
      IDLE: if (bus.go) begin
        k_d     = '0;
        k_len_d = bus.k_len;
      end
      FEED: begin
        k_d  = k_last_c ? '0 : k_q + K_W'(1);
        fl_d = '0;
      end
      FLUSH:   fl_d = fl_q + FL_W'(1);
      default: ;
    endcase
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    rd_en_d = (state_d == FEED);
    pe_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q      <= '0;
      k_len_q  <= '0;
      fl_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      pe_q     <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      k_q      <= k_d;
      k_len_q  <= k_len_d;
      fl_q     <= fl_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      pe_q     <= pe_d;
      rd_vld_q <= rd_en_q;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = ADDR_W'(k_q);
  assign bus.pe_start = pe_q;

  // Read data is only trusted the cycle after a strobe; otherwise lanes are zero-filled
  for (genvar i = 0; i < int'(N); i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_in, b_in;
    assign a_in = rd_vld_q ? `LANE_SLICE(bus.rd_a_data, i, DATA_WIDTH) : '0;
    assign b_in = rd_vld_q ? `LANE_SLICE(bus.rd_b_data, i, DATA_WIDTH) : '0;

    if (i == 0) begin : g_direct
      assign `LANE_SLICE(bus.a_edge, i, DATA_WIDTH) = a_in;
      assign `LANE_SLICE(bus.b_edge, i, DATA_WIDTH) = b_in;
    end else begin : g_skew
      skew_line #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_skew_a (
        .clk   (clk),
        .reset (reset),
        .d     (a_in),
        .q     (`LANE_SLICE(bus.a_edge, i, DATA_WIDTH))
      );
      skew_line #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_skew_b (
        .clk   (clk),
        .reset (reset),
        .d     (b_in),
        .q     (`LANE_SLICE(bus.b_edge, i, DATA_WIDTH))
      );
    end
  end

`ifdef FEEDER_CYCLE_CNT_EN
  // Cleared on accepted go, counts FEED/FLUSH cycles, saturates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else if (state_q == IDLE && bus.go) begin
      cycle_cnt <= '0;
    end else if ((state_q == FEED || state_q == FLUSH) && cycle_cnt != '1) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_matmul_operand_feeder.sv
// Scoreboard bench for matmul_operand_feeder: SRAM model, timed edge expectations, PE-grid matmul model.
// Build with FEEDER_CYCLE_CNT_EN defined to also check cycle_cnt.
module tb_matmul_operand_feeder;
  import matmul_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned KW = 8;
  localparam int unsigned W  = N * DW;
  localparam int unsigned F  = 1 + 3 * (N - 1) + 2;

  typedef struct {
    int unsigned  cyc;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } edge_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          vecs = 0;
  int          errs = 0;
  int unsigned rd_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matmul_operand_feeder_if #(.N(N), .DATA_WIDTH(DW), .ADDR_W(AW), .K_W(KW)) bus ();
`ifdef FEEDER_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  matmul_operand_feeder #(.N(N), .DATA_WIDTH(DW), .ADDR_W(AW), .K_W(KW)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef FEEDER_CYCLE_CNT_EN
    .cycle_cnt (cycle_cnt),
`endif
    .bus       (bus)
  );

  logic [DW-1:0] mem_a [256][N];
  logic [DW-1:0] mem_b [256][N];
  int unsigned   exp_addr [$];
  edge_t         exp_edge [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Operand SRAM: one-cycle read latency, junk on the bus when not reading
  always @(posedge clk) begin
    logic [W-1:0] ta, tb;
    for (int i = 0; i < int'(N); i++) begin
      ta[i*DW +: DW] = bus.rd_en ? mem_a[bus.rd_addr][i] : DW'($urandom);
      tb[i*DW +: DW] = bus.rd_en ? mem_b[bus.rd_addr][i] : DW'($urandom);
    end
    bus.rd_a_data <= ta;
    bus.rd_b_data <= tb;
  end

  // Behavioural PE grid: PE(i,j) sees a lane i after j hops and b lane j after i hops
  logic [DW-1:0] ha [N][N];
  logic [DW-1:0] hb [N][N];
  logic [31:0]   acc [N][N];

  initial begin
    for (int d = 0; d < int'(N); d++)
      for (int i = 0; i < int'(N); i++) begin
        ha[d][i] = '0; hb[d][i] = '0; acc[d][i] = '0;
      end
  end

  // Monitor: reads, edges and PE model, sampled on the falling edge
  always @(negedge clk) begin
    edge_t        e;
    logic [W-1:0] ea, eb;
    if (bus.rd_en) begin
      rd_cnt++;
      if (exp_addr.size() == 0) chk("rd_en_unexpected", 64'(bus.rd_en), 64'(0));
      else chk("rd_addr", 64'(bus.rd_addr), 64'(exp_addr.pop_front()));
    end
    ea = '0;
    eb = '0;
    if (exp_edge.size() != 0 && exp_edge[0].cyc == cyc) begin
      e  = exp_edge.pop_front();
      ea = e.a;
      eb = e.b;
    end
    chk("a_edge", 64'(bus.a_edge), 64'(ea));
    chk("b_edge", 64'(bus.b_edge), 64'(eb));
    for (int d = int'(N) - 1; d > 0; d--)
      for (int i = 0; i < int'(N); i++) begin
        ha[d][i] = ha[d-1][i];
        hb[d][i] = hb[d-1][i];
      end
    for (int i = 0; i < int'(N); i++) begin
      ha[0][i] = bus.a_edge[i*DW +: DW];
      hb[0][i] = bus.b_edge[i*DW +: DW];
    end
    for (int i = 0; i < int'(N); i++)
      for (int j = 0; j < int'(N); j++)
        acc[i][j] = bus.pe_start ? acc[i][j] + 32'(ha[j][i]) * 32'(hb[i][j]) : 32'd0;
  end

  function automatic logic [31:0] ref_c(input int i, input int j, input int k);
    logic [31:0] s = '0;
    for (int kk = 0; kk < k; kk++) s = s + 32'(mem_a[kk][i]) * 32'(mem_b[kk][j]);
    return s;
  endfunction

  // mode 0: random data, 1: A[k][i]=16k+i, 2: A=1..16 row-major with identity B
  task automatic run(input int unsigned k, input int mode, input bit inject);
    int unsigned  t0, exp_done, n, budget;
    logic [W-1:0] a, b;
    for (int kk = 0; kk < int'(k); kk++)
      for (int i = 0; i < int'(N); i++) begin
        case (mode)
          1:       begin mem_a[kk][i] = DW'(16 * kk + i); mem_b[kk][i] = DW'($urandom); end
          2:       begin mem_a[kk][i] = DW'(4 * i + kk + 1); mem_b[kk][i] = (kk == i) ? DW'(1) : DW'(0); end
          default: begin mem_a[kk][i] = DW'($urandom); mem_b[kk][i] = DW'($urandom); end
        endcase
      end
    @(posedge clk); #1;
    chk("pe_start_idle", 64'(bus.pe_start), 64'(0));
    chk("busy_idle", 64'(bus.busy), 64'(0));
    bus.go    = 1'b1;
    bus.k_len = KW'(k);
    t0        = cyc + 1;
    rd_cnt    = 0;
    for (int kk = 0; kk < int'(k); kk++) exp_addr.push_back(kk);
    if (k > 0) begin
      for (int o = 1; o < int'(k + N); o++) begin
        a = '0;
        b = '0;
        for (int i = 0; i < int'(N); i++) begin
          int kk = o - 1 - i;
          if (kk >= 0 && kk < int'(k)) begin
            a[i*DW +: DW] = mem_a[kk][i];
            b[i*DW +: DW] = mem_b[kk][i];
          end
        end
        exp_edge.push_back('{cyc: t0 + o, a: a, b: b});
      end
    end
    exp_done = (k == 0) ? t0 : t0 + k + F;
    @(posedge clk); #1;
    bus.go    = 1'b0;
    bus.k_len = KW'($urandom);
    chk("pe_start_rise", 64'(bus.pe_start), 64'(1));
    chk("busy_rise", 64'(bus.busy), 64'(1));
    n      = 0;
    budget = k + F + 20;
    while (!bus.done && n < budget) begin
      if (inject) begin
        if (cyc < t0 + k) bus.done_ack = 1'($urandom);
        else if (cyc < t0 + k + F) bus.go = 1'($urandom);
      end
      @(posedge clk); #1;
      bus.go       = 1'b0;
      bus.done_ack = 1'b0;
      n++;
    end
    chk("done_cycle", 64'(cyc), 64'(exp_done));
    chk("done_seen", 64'(bus.done), 64'(1));
    chk("rd_count", 64'(rd_cnt), 64'(k));
    chk("rd_outstanding", 64'(exp_addr.size()), 64'(0));
    chk("pe_start_done", 64'(bus.pe_start), 64'(1));
    chk("busy_done", 64'(bus.busy), 64'(1));
    for (int i = 0; i < int'(N); i++)
      for (int j = 0; j < int'(N); j++)
        chk($sformatf("pe_c_%0d_%0d", i, j), 64'(acc[i][j]), 64'(ref_c(i, j, int'(k))));
`ifdef FEEDER_CYCLE_CNT_EN
    chk("cycle_cnt_done", 64'(cycle_cnt), 64'((k == 0) ? 0 : k + F));
`endif
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
    end
    chk("done_hold", 64'(bus.done), 64'(1));
    bus.done_ack = 1'b1;
    @(posedge clk); #1;
    bus.done_ack = 1'b0;
    chk("done_clear", 64'(bus.done), 64'(0));
    chk("pe_start_fall", 64'(bus.pe_start), 64'(0));
    chk("busy_clear", 64'(bus.busy), 64'(0));
`ifdef FEEDER_CYCLE_CNT_EN
    chk("cycle_cnt_frozen", 64'(cycle_cnt), 64'((k == 0) ? 0 : k + F));
`endif
  endtask

  initial begin
    reset        = 1'b0;
    bus.go       = 1'b0;
    bus.k_len    = '0;
    bus.done_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 64'(bus.rd_en), 64'(0));
    chk("rst_rd_addr", 64'(bus.rd_addr), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_pe_start", 64'(bus.pe_start), 64'(0));
    chk("rst_a_edge", 64'(bus.a_edge), 64'(0));
    chk("rst_b_edge", 64'(bus.b_edge), 64'(0));
`ifdef FEEDER_CYCLE_CNT_EN
    chk("rst_cycle_cnt", 64'(cycle_cnt), 64'(0));
`endif
    reset = 1'b1;

    run(3, 1, 1'b0);
    run(4, 2, 1'b0);
    run(0, 0, 1'b0);
    run(5, 0, 1'b1);
    for (int r = 0; r < 8; r++) run($urandom_range(1, 20), 0, 1'b1);
    run(255, 0, 1'b0);

    // Reset in the middle of FEED while address 1 is being read
    for (int kk = 0; kk < 10; kk++)
      for (int i = 0; i < int'(N); i++) mem_a[kk][i] = DW'($urandom);
    @(posedge clk); #1;
    bus.go    = 1'b1;
    bus.k_len = KW'(10);
    exp_addr.push_back(0);
    @(posedge clk); #1;
    bus.go = 1'b0;
    @(posedge clk); #1;
    chk("mid_rd_addr", 64'(bus.rd_addr), 64'(1));
    reset = 1'b0;
    exp_addr.delete();
    exp_edge.delete();
    #1;
    chk("mid_rst_rd_en", 64'(bus.rd_en), 64'(0));
    chk("mid_rst_pe_start", 64'(bus.pe_start), 64'(0));
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_a_edge", 64'(bus.a_edge), 64'(0));
    chk("mid_rst_b_edge", 64'(bus.b_edge), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run(6, 0, 1'b1);
    run(1, 0, 1'b0);

    repeat (N + 2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
